wbs_regbank: RTL and testbench
==============================

Name: wbs_regbank

Overview:
Parameterised Wishbone classic slave that generalises the single-register slave template into a bank of NUM_RW_REGS read/write control registers and NUM_RO_REGS read-only status registers.
- Byte-enabled writes, error response on illegal accesses, optional interrupt block.
- Sits between the Wishbone interconnect and fabric logic; control registers drive fabric, status inputs are sampled from fabric.

Parameters:
BUS_DATA_WIDTH, 32, data width; multiple of 8, range 8..64
BUS_ADDR_WIDTH, 8, address width; range 4..32
DEV_BASE_ADDR, 0, first word address of the bank
NUM_RW_REGS, 4, number of RW control registers (>=1)
NUM_RO_REGS, 4, number of RO status registers (>=0)
RW_RESET_VAL, 0, reset value of every RW register (BUS_DATA_WIDTH bits)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  asynchronous, active-low reset
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  1=write, 0=read
wbs_sel_i  in  BUS_DATA_WIDTH/8  byte enables
wbs_adr_i  in  BUS_ADDR_WIDTH  word address
wbs_dat_i  in  BUS_DATA_WIDTH  write data
wbs_dat_o  out  BUS_DATA_WIDTH  read data
wbs_ack_o  out  1  normal termination
wbs_err_o  out  1  error termination
wbs_int_o  out  1  interrupt request
ctrl_o  out  NUM_RW_REGS*BUS_DATA_WIDTH  RW registers, reg k at bits [k*W +: W]
status_i  in  max(NUM_RO_REGS,1)*BUS_DATA_WIDTH  fabric status, same packing
irq_evt_i  in  BUS_DATA_WIDTH  interrupt event pulses (used only with WBS_REGBANK_IRQ_EN)

Behaviour:
- Reset (wb_rst_i=0, takes effect immediately, asynchronously):
  - wbs_dat_o=0, wbs_ack_o=0, wbs_err_o=0, wbs_int_o=0.
  - RW regs=RW_RESET_VAL; status sample regs=0; IRQ regs=0.
  - A transfer in flight at reset is dropped and never terminated.
- Offset = wbs_adr_i - DEV_BASE_ADDR, computed in BUS_ADDR_WIDTH+1 bits. adr < base is illegal, never wrapped.
- Map:
  - 0..NUM_RW_REGS-1 = RW regs.
  - NUM_RW_REGS..NUM_RW_REGS+NUM_RO_REGS-1 = RO regs.
  - The next two offsets are the IRQ regs (feature only).
  - All other offsets are illegal.
- Accept condition: cyc & stb & ~ack_o & ~err_o. When it holds at a rising edge, exactly one of ack_o/err_o is high in the following cycle for exactly one cycle. Latency is 1; ack_o and err_o are never both high.
- If stb is still high after termination, the next transfer is accepted the cycle after. Maximum throughput is one transfer per 2 cycles.
- Write to an RW reg: for each byte b with sel[b]=1, reg[8b+7:8b] <= dat_i at the accept edge, visible on ctrl_o the next cycle. sel=0 gives ack with no change.
- Write to an RO reg or an illegal offset: err, no state change.
- Read of a legal offset: wbs_dat_o loaded at the accept edge, valid while ack_o is high; sel is ignored.
- Read of an illegal offset: err, wbs_dat_o unchanged.
- wbs_dat_o holds its last value between transfers; it is never driven X.
- status_i is registered every cycle. A read returns the value sampled at the edge before the accept edge (2-flop delay from status_i to dat_o).
- cyc low with stb high: ignored.

Optional Feature:
Macro WBS_REGBANK_IRQ_EN.
- Defined:
  - IRQ_PEND at offset NUM_RW_REGS+NUM_RO_REGS:
    - Each bit is set by irq_evt_i[b]=1 at any edge.
    - A write with dat_i[b]=1 in an enabled byte clears bit b (write-1-to-clear).
    - Set and clear of the same bit in the same cycle: set wins.
  - IRQ_MASK at the next offset: plain byte-enabled RW, reset 0.
  - wbs_int_o <= |(IRQ_PEND & IRQ_MASK), registered: one cycle after the pending/mask change.
- Not defined:
  - Both offsets are illegal (err).
  - wbs_int_o is constant 0; irq_evt_i is unused.

Test Plan:
1. Reset release, read offset 0 with defaults -> ack one cycle after stb, dat_o=32'h0; err_o stays 0.
2. Write 32'hAABBCCDD to offset 1 with sel=4'b0101, then read offset 1 -> ctrl_o reg1 = 32'h00BB00DD and read returns 32'h00BB00DD; each access terminates with a single-cycle ack.
3. Write to offset 4 (RO) and read offset 12 (illegal, no IRQ) -> err_o one cycle each, ack_o 0, ctrl_o unchanged, dat_o unchanged. With DEV_BASE_ADDR=8, access to adr 3 -> err.
4. status_i reg0 = 32'h12345678 for 2 cycles, then read offset 4 -> dat_o=32'h12345678. stb held high across 3 reads -> 3 acks on alternating cycles.
5. IRQ_EN: write MASK=1, pulse irq_evt_i[0] -> int_o=1 two cycles later. Then W1C of bit 0 in the same cycle as a new evt[0] -> PEND[0] stays 1 and int_o stays 1.
6. Assert wb_rst_i=0 in the cycle ack_o is high after a write -> ack_o drops immediately, ctrl_o returns to RW_RESET_VAL, no further ack after reset release.

Source files
------------

// File: rtl/wbs_regbank.sv
// Wishbone classic slave holding a bank of RW control and RO status registers.
// Define WBS_REGBANK_IRQ_EN to add the IRQ_PEND/IRQ_MASK pair and wbs_int_o.
module wbs_regbank #(
  parameter int                         BUS_DATA_WIDTH = 32,
  parameter int                         BUS_ADDR_WIDTH = 8,
  parameter logic [BUS_ADDR_WIDTH-1:0]  DEV_BASE_ADDR  = '0,
  parameter int                         NUM_RW_REGS    = 4,
  parameter int                         NUM_RO_REGS    = 4,
  parameter logic [BUS_DATA_WIDTH-1:0]  RW_RESET_VAL   = '0
) (
  input  logic                                    wb_clk_i,
  input  logic                                    wb_rst_i,
  input  logic                                    wbs_cyc_i,
  input  logic                                    wbs_stb_i,
  input  logic                                    wbs_we_i,
  input  logic [BUS_DATA_WIDTH/8-1:0]             wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]               wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]               wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]               wbs_dat_o,
  output logic                                    wbs_ack_o,
  output logic                                    wbs_err_o,
  output logic                                    wbs_int_o,
  output logic [NUM_RW_REGS*BUS_DATA_WIDTH-1:0]   ctrl_o,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*BUS_DATA_WIDTH-1:0] status_i,
  input  logic [BUS_DATA_WIDTH-1:0]               irq_evt_i
);

  localparam int W    = BUS_DATA_WIDTH;
  localparam int SELW = BUS_DATA_WIDTH / 8;
  localparam int OW   = BUS_ADDR_WIDTH + 1;
  localparam int NRO1 = (NUM_RO_REGS > 0) ? NUM_RO_REGS : 1;
  localparam logic [OW-1:0] L_RO_BASE  = OW'(NUM_RW_REGS);
  localparam logic [OW-1:0] L_IRQ_BASE = OW'(NUM_RW_REGS + NUM_RO_REGS);

  // Handshake: a transfer is accepted on a rising edge where cyc & stb are high
  // and no termination is currently shown; exactly one of ack/err follows for one
  // cycle, so back-to-back transfers with stb held high run at one per two cycles.
  logic                 w_accept;
  logic [OW-1:0]        w_offset;
  logic                 w_hit_rw;
  logic                 w_hit_ro;
  logic                 w_hit_pend;
  logic                 w_hit_mask;
  logic                 w_ok;
  logic                 w_wr;
  logic [W-1:0]         w_bmask;
  logic [W-1:0]         w_rdata;

  logic [NUM_RW_REGS-1:0][W-1:0] r_ctrl;
  logic [NRO1-1:0][W-1:0]        r_status;
  logic [W-1:0]                  r_dat;
  logic                          r_ack;
  logic                          r_err;

  assign w_accept = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;

  // Extra top bit makes adr < base a huge offset, so it can never alias a register.
  assign w_offset = {1'b0, wbs_adr_i} - {1'b0, DEV_BASE_ADDR};
  assign w_hit_rw = (w_offset < L_RO_BASE);
  assign w_hit_ro = (w_offset >= L_RO_BASE) && (w_offset < L_IRQ_BASE);

`ifdef WBS_REGBANK_IRQ_EN
  assign w_hit_pend = (w_offset == L_IRQ_BASE);
  assign w_hit_mask = (w_offset == OW'(NUM_RW_REGS + NUM_RO_REGS + 1));
`else
  assign w_hit_pend = 1'b0;
  assign w_hit_mask = 1'b0;
`endif

  assign w_ok = wbs_we_i ? (w_hit_rw | w_hit_pend | w_hit_mask)
                         : (w_hit_rw | w_hit_ro | w_hit_pend | w_hit_mask);
  assign w_wr = w_accept & wbs_we_i & w_ok;

  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < SELW; b++) begin
      w_bmask[8*b +: 8] = {8{wbs_sel_i[b]}};
    end
  end

`ifdef WBS_REGBANK_IRQ_EN
  logic [W-1:0] r_pend;
  logic [W-1:0] r_mask;
  logic         r_int;
  logic [W-1:0] w_clr;

  assign w_clr = (w_wr && w_hit_pend) ? (wbs_dat_i & w_bmask) : '0;

  // New events are OR-ed in after the clear so a simultaneous set wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_pend <= '0;
      r_mask <= '0;
      r_int  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | irq_evt_i;
      if (w_wr && w_hit_mask) begin
        r_mask <= (r_mask & ~w_bmask) | (wbs_dat_i & w_bmask);
      end
      r_int <= |(r_pend & r_mask);
    end
  end

  assign wbs_int_o = r_int;
`else
  logic w_unused_evt;
  assign w_unused_evt = ^irq_evt_i;
  assign wbs_int_o    = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NUM_RW_REGS; k++) begin
      if (w_offset == OW'(k)) w_rdata = r_ctrl[k];
    end
    for (int k = 0; k < NUM_RO_REGS; k++) begin
      if (w_offset == OW'(NUM_RW_REGS + k)) w_rdata = r_status[k];
    end
`ifdef WBS_REGBANK_IRQ_EN
    if (w_hit_pend) w_rdata = r_pend;
    if (w_hit_mask) w_rdata = r_mask;
`endif
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_status <= '0;
    end else begin
      r_status <= status_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ctrl <= {NUM_RW_REGS{RW_RESET_VAL}};
    end else if (w_wr && w_hit_rw) begin
      for (int k = 0; k < NUM_RW_REGS; k++) begin
        if (w_offset == OW'(k)) begin
          r_ctrl[k] <= (r_ctrl[k] & ~w_bmask) | (wbs_dat_i & w_bmask);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_accept & w_ok;
      r_err <= w_accept & ~w_ok;
      if (w_accept && !wbs_we_i && w_ok) begin
        r_dat <= w_rdata;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_dat_o = r_dat;
  assign ctrl_o    = r_ctrl;

endmodule

// File: tb/tb_wbs_regbank.sv
// Directed bench for wbs_regbank: a base-0 bank and a base-8 bank share one bus.
module tb_wbs_regbank;

  logic         clk;
  logic         rst_n;
  logic         cyc, stb, cyc_b, stb_b;
  logic         we;
  logic [3:0]   sel;
  logic [7:0]   adr;
  logic [31:0]  dat_w;
  logic [127:0] status;
  logic [31:0]  evt;

  logic [31:0]  dat_o, dat_o_b;
  logic         ack, err, irq, ack_b, err_b, irq_b;
  logic [127:0] ctrl, ctrl_b;

  logic [31:0]  exp_q[$];
  logic [31:0]  m_dat;
  int           checks;
  int           errors;
  int           n_ack;

  wbs_regbank u_dut (
    .wb_clk_i (clk), .wb_rst_i (rst_n),
    .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we), .wbs_sel_i (sel),
    .wbs_adr_i (adr), .wbs_dat_i (dat_w), .wbs_dat_o (dat_o),
    .wbs_ack_o (ack), .wbs_err_o (err), .wbs_int_o (irq),
    .ctrl_o (ctrl), .status_i (status), .irq_evt_i (evt)
  );

  wbs_regbank #(.DEV_BASE_ADDR(8'd8)) u_dut_b (
    .wb_clk_i (clk), .wb_rst_i (rst_n),
    .wbs_cyc_i (cyc_b), .wbs_stb_i (stb_b), .wbs_we_i (we), .wbs_sel_i (sel),
    .wbs_adr_i (adr), .wbs_dat_i (dat_w), .wbs_dat_o (dat_o_b),
    .wbs_ack_o (ack_b), .wbs_err_o (err_b), .wbs_int_o (irq_b),
    .ctrl_o (ctrl_b), .status_i (status), .irq_evt_i (evt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer: accept on the first edge, termination checked right
  // after it, then the bus is released and the termination must be gone.
  task automatic xfer(input bit to_b, input logic w, input logic [7:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
    logic [31:0] e;
    @(negedge clk);
    we = w; adr = a; sel = s; dat_w = d;
    if (to_b) begin cyc_b = 1'b1; stb_b = 1'b1; end
    else      begin cyc   = 1'b1; stb   = 1'b1; end
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    chk({tag, "_term"}, to_b ? {ack_b, err_b} : {ack, err}, exp_err ? 2'b01 : 2'b10);
    e = exp_q.pop_front();
    if (!w) chk({tag, "_dat"}, to_b ? dat_o_b : dat_o, e);
    cyc = 1'b0; stb = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_single"}, to_b ? {ack_b, err_b} : {ack, err}, 2'b00);
  endtask

  initial begin
    checks = 0; errors = 0; n_ack = 0;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    we = 1'b0; sel = 4'h0; adr = 8'h0; dat_w = 32'h0; evt = 32'h0;
    status = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    m_dat = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_err_int", {ack, err, irq}, 3'b000);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_ctrl", ctrl, 128'h0);
    chk("rst_ctrl_b", ctrl_b, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // defaults and byte-enabled writes
    xfer(0, 1'b0, 8'd0, 4'hF, 32'h0, 1'b0, 32'h0, "rd0_default");
    xfer(0, 1'b1, 8'd1, 4'b0101, 32'hAABB_CCDD, 1'b0, 32'h0, "wr1_sel0101");
    chk("ctrl1_after_wr", ctrl[63:32], 32'h00BB_00DD);
    xfer(0, 1'b0, 8'd1, 4'h0, 32'h0, 1'b0, 32'h00BB_00DD, "rd1");
    xfer(0, 1'b1, 8'd0, 4'hF, 32'h1122_3344, 1'b0, 32'h0, "wr0_full");
    xfer(0, 1'b1, 8'd0, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr0_sel0");
    xfer(0, 1'b0, 8'd0, 4'hF, 32'h0, 1'b0, 32'h1122_3344, "rd0");
    xfer(0, 1'b1, 8'd3, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0, "wr3_top_byte");
    xfer(0, 1'b0, 8'd3, 4'hF, 32'h0, 1'b0, 32'hA500_0000, "rd3_last_rw");
    m_dat = 32'hA500_0000;

    // illegal accesses
    xfer(0, 1'b1, 8'd4, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr4_ro");
    chk("ctrl_after_ro_wr", ctrl, {32'hA500_0000, 32'h0, 32'h00BB_00DD, 32'h1122_3344});
    xfer(0, 1'b0, 8'd12, 4'hF, 32'h0, 1'b1, m_dat, "rd12_illegal");
    xfer(0, 1'b0, 8'd7, 4'hF, 32'h0, 1'b0, 32'h3333_0003, "rd7_last_ro");
    xfer(1, 1'b0, 8'd3, 4'hF, 32'h0, 1'b1, 32'h0, "b_rd3_below_base");
    xfer(1, 1'b1, 8'd3, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, "b_wr3_below_base");
    xfer(1, 1'b1, 8'd9, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, "b_wr9");
    xfer(1, 1'b0, 8'd9, 4'hF, 32'h0, 1'b0, 32'h0BAD_F00D, "b_rd9");
    chk("b_ctrl", ctrl_b, {32'h0, 32'h0, 32'h0BAD_F00D, 32'h0});

    // status sampling
    @(negedge clk);
    status[31:0] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    xfer(0, 1'b0, 8'd4, 4'hF, 32'h0, 1'b0, 32'h1234_5678, "rd4_status");

    // stb held high for three reads: acks on alternating cycles
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd5; sel = 4'hF;
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) exp_q.push_back(32'h1111_0001);
      @(posedge clk); #1;
      chk($sformatf("burst_ack_c%0d", c), ack, (c % 2 == 0) ? 1'b1 : 1'b0);
      if (ack) begin
        n_ack++;
        chk($sformatf("burst_dat_c%0d", c), dat_o, exp_q.pop_front());
      end
      if (c == 4) begin cyc = 1'b0; stb = 1'b0; end
    end
    chk("burst_ack_count", n_ack, 3);
    chk("burst_queue_empty", exp_q.size(), 0);
    m_dat = 32'h1111_0001;

`ifdef WBS_REGBANK_IRQ_EN
    xfer(0, 1'b1, 8'd9, 4'hF, 32'h1, 1'b0, 32'h0, "wr_mask");
    @(negedge clk);
    evt = 32'h1;
    @(posedge clk); #1;
    chk("int_first_edge", irq, 1'b0);
    @(negedge clk);
    evt = 32'h0;
    @(posedge clk); #1;
    chk("int_raised", irq, 1'b1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd8; sel = 4'hF; dat_w = 32'h1;
    evt = 32'h1;
    @(posedge clk); #1;
    chk("w1c_race_ack", {ack, err}, 2'b10);
    cyc = 1'b0; stb = 1'b0; evt = 32'h0;
    @(posedge clk); #1;
    chk("int_kept_set_wins", irq, 1'b1);
    xfer(0, 1'b0, 8'd8, 4'hF, 32'h0, 1'b0, 32'h1, "rd_pend_kept");
    xfer(0, 1'b1, 8'd8, 4'hF, 32'h1, 1'b0, 32'h0, "w1c_clean");
    chk("int_cleared", irq, 1'b0);
`else
    xfer(0, 1'b0, 8'd8, 4'hF, 32'h0, 1'b1, m_dat, "rd8_no_irq");
    xfer(0, 1'b1, 8'd9, 4'hF, 32'h1, 1'b1, 32'h0, "wr9_no_irq");
    @(negedge clk);
    evt = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("int_const_zero", irq, 1'b0);
    evt = 32'h0;
`endif

    // reset asserted while a write ack is showing
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd2; sel = 4'hF; dat_w = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rst_mid_ack_before", {ack, ctrl[95:64]}, {1'b1, 32'hDEAD_BEEF});
    #1;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    #1;
    chk("rst_mid_ack_dropped", {ack, err}, 2'b00);
    chk("rst_mid_ctrl", ctrl, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack || err) n_ack++;
    end
    chk("no_term_after_rst", n_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
